// File: rtl/io_mailbox.sv
// Memory-mapped byte mailbox between the Core bus and an external
// valid/ready producer/consumer, with one RX and one TX FIFO.
module io_mailbox #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        ENABLE,
  input  logic [12:0] ADDRESS,
  inout  wire  [7:0]  DATA,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        IRQ
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [7:0]    r_rx_mem [DEPTH];
  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic [AW:0]   r_rx_cnt, r_tx_cnt;
  logic          r_rx_unf, r_tx_ovf;
  logic          r_rd_q, r_wr_q;

  logic       w_rd, w_wr, w_rd_edge, w_wr_edge;
  logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic       w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic       w_unf_set, w_ovf_set, w_clr;
  logic       w_drive;
  logic [7:0] w_status, w_rdata;
  logic [1:0] w_addr;
  logic       w_unused;

  assign w_addr   = ADDRESS[1:0];
  assign w_unused = ^ADDRESS[12:2];

  assign w_rd      = ENABLE && MEM_RD;
  assign w_wr      = ENABLE && MEM_WR;
  assign w_rd_edge = w_rd && !r_rd_q;
  assign w_wr_edge = w_wr && !r_wr_q;

  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);

  assign w_rx_push = IN_VALID && !w_rx_full;
  assign w_rx_pop  = w_rd_edge && (w_addr == 2'd0) && !w_rx_empty;
  assign w_unf_set = w_rd_edge && (w_addr == 2'd0) && w_rx_empty;
  assign w_tx_push = w_wr_edge && (w_addr == 2'd1) && !w_tx_full;
  assign w_ovf_set = w_wr_edge && (w_addr == 2'd1) && w_tx_full;
  assign w_tx_pop  = !w_tx_empty && OUT_READY;
  assign w_clr     = w_wr_edge && (w_addr == 2'd2) && DATA[0];

  assign IN_READY  = !w_rx_full;
  assign OUT_VALID = !w_tx_empty;
  assign OUT_DATA  = r_tx_mem[r_tx_rp];
  assign IRQ       = !w_rx_empty || r_rx_unf || r_tx_ovf;

  assign w_status = {2'b00, r_rx_unf, r_tx_ovf,
                     w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

  always_comb begin
    w_rdata = 8'h00;
    unique case (w_addr)
      2'd0: w_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
      2'd1: w_rdata = 8'h00;
      2'd2: w_rdata = w_status;
      2'd3: w_rdata = {{(7-AW){1'b0}}, r_rx_cnt};
      default: w_rdata = 8'h00;
    endcase
  end

  assign w_drive = ENABLE && MEM_RD && !MEM_WR;
  assign DATA    = w_drive ? w_rdata : 8'bz;

  // Storage is deliberately left out of reset.
  always_ff @(posedge SYS_CLK) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= IN_DATA;
    if (w_tx_push) r_tx_mem[r_tx_wp] <= DATA;
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_unf <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_rd_q   <= 1'b0;
      r_wr_q   <= 1'b0;
    end else begin
      r_rd_q <= w_rd;
      r_wr_q <= w_wr;
      if (w_rx_push) r_rx_wp <= r_rx_wp + ONE_PTR;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + ONE_PTR;
      if (w_rx_push && !w_rx_pop)
        r_rx_cnt <= r_rx_cnt + ONE_CNT;
      else if (w_rx_pop && !w_rx_push)
        r_rx_cnt <= r_rx_cnt - ONE_CNT;
      if (w_tx_push) r_tx_wp <= r_tx_wp + ONE_PTR;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + ONE_PTR;
      if (w_tx_push && !w_tx_pop)
        r_tx_cnt <= r_tx_cnt + ONE_CNT;
      else if (w_tx_pop && !w_tx_push)
        r_tx_cnt <= r_tx_cnt - ONE_CNT;
      // Setting a sticky flag takes priority over clearing it.
      if (w_unf_set)  r_rx_unf <= 1'b1;
      else if (w_clr) r_rx_unf <= 1'b0;
      if (w_ovf_set)  r_tx_ovf <= 1'b1;
      else if (w_clr) r_tx_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_mailbox.sv
// Scoreboard bench for io_mailbox: Core reads and TX handshakes
// are checked by monitors against queued expectations.
module tb_io_mailbox;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST;
  logic        ENABLE;
  logic [12:0] ADDRESS;
  wire  [7:0]  DATA;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [7:0]  IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        IRQ;

  logic       tb_drv;
  logic [7:0] tb_dout;
  assign DATA = tb_drv ? tb_dout : 8'bz;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rd_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_q[$];

  io_mailbox #(.DEPTH(8), .AW(3)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .ENABLE(ENABLE),
    .ADDRESS(ADDRESS), .DATA(DATA), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .IRQ(IRQ)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic core_read(logic [1:0] a, logic [7:0] exp,
                           string name, int hold);
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    ENABLE  = 1'b1;
    ADDRESS = {11'd0, a};
    MEM_RD  = 1'b1;
    repeat (hold) tick();
    MEM_RD = 1'b0;
    ENABLE = 1'b0;
    tick();
  endtask

  task automatic core_write(logic [1:0] a, logic [7:0] d);
    ENABLE  = 1'b1;
    ADDRESS = {11'd0, a};
    tb_drv  = 1'b1;
    tb_dout = d;
    MEM_WR  = 1'b1;
    tick();
    MEM_WR = 1'b0;
    ENABLE = 1'b0;
    tb_drv = 1'b0;
    tick();
  endtask

  task automatic ext_push(logic [7:0] d);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic drain_tx(string name);
    int n;
    n = 0;
    OUT_READY = 1'b1;
    while (OUT_VALID && n < 20) begin
      tick();
      n++;
    end
    OUT_READY = 1'b0;
    chk({name, "_drained"}, {7'd0, OUT_VALID}, 8'h00);
  endtask

  // Read monitor: compare on the first cycle of each read access.
  logic mon_prev = 1'b0;
  always @(negedge SYS_CLK) begin
    logic cur;
    cur = ENABLE && MEM_RD && !MEM_WR;
    if (cur && !mon_prev) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got %h expected none", DATA);
      end else begin
        chk(rd_name_q.pop_front(), DATA, rd_q.pop_front());
      end
    end
    mon_prev = cur;
  end

  // TX monitor: every accepted OUT_DATA is checked against the queue.
  always @(negedge SYS_CLK) begin
    if (OUT_VALID && OUT_READY) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx: got %h expected none", OUT_DATA);
      end else begin
        chk("tx_data", OUT_DATA, tx_q.pop_front());
      end
    end
  end

  initial begin
    SYS_RST = 1'b1; ENABLE = 1'b0; ADDRESS = '0;
    MEM_RD = 1'b0; MEM_WR = 1'b0; IN_DATA = '0;
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    tb_drv = 1'b0; tb_dout = '0;
    repeat (3) tick();
    SYS_RST = 1'b0;
    tick();

    chk("rst_in_ready", {7'd0, IN_READY}, 8'h01);
    chk("rst_out_valid", {7'd0, OUT_VALID}, 8'h00);
    chk("rst_irq", {7'd0, IRQ}, 8'h00);
    core_read(2'd2, 8'h05, "rst_status", 1);

    ext_push(8'hA1);
    ext_push(8'hB2);
    core_read(2'd3, 8'h02, "cnt_2", 1);
    core_read(2'd0, 8'hA1, "pop_a1", 3);
    core_read(2'd3, 8'h01, "cnt_1", 1);
    chk("irq_one_left", {7'd0, IRQ}, 8'h01);
    core_read(2'd0, 8'hB2, "pop_b2", 3);
    core_read(2'd3, 8'h00, "cnt_0", 1);
    chk("irq_after_pops", {7'd0, IRQ}, 8'h00);
    core_read(2'd2, 8'h05, "status_empty", 1);

    for (int i = 0; i < 8; i++) ext_push(8'h10 + 8'(i));
    chk("rx_full_in_ready", {7'd0, IN_READY}, 8'h00);
    core_read(2'd2, 8'h06, "status_rx_full", 1);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h99;
    tick();
    core_read(2'd3, 8'h08, "cnt_full_blocked", 1);
    core_read(2'd0, 8'h10, "pop_head_full", 1);
    IN_VALID = 1'b0;
    core_read(2'd3, 8'h08, "cnt_refill", 1);
    for (int i = 1; i < 8; i++)
      core_read(2'd0, 8'h10 + 8'(i), "drain_rx", 1);
    core_read(2'd0, 8'h99, "drain_9th", 1);
    chk("irq_rx_drained", {7'd0, IRQ}, 8'h00);

    for (int i = 0; i < 9; i++) core_write(2'd1, 8'h20 + 8'(i));
    chk("tx_out_valid", {7'd0, OUT_VALID}, 8'h01);
    chk("tx_ovf_irq", {7'd0, IRQ}, 8'h01);
    core_read(2'd2, 8'h19, "status_tx_ovf", 1);
    core_read(2'd1, 8'h00, "read_tx_addr", 1);
    for (int i = 0; i < 8; i++) tx_q.push_back(8'h20 + 8'(i));
    drain_tx("tx8");
    core_read(2'd2, 8'h15, "status_ovf_only", 1);

    core_read(2'd0, 8'h00, "underflow_read", 1);
    core_read(2'd2, 8'h35, "status_unf_ovf", 1);
    chk("irq_flags", {7'd0, IRQ}, 8'h01);
    core_write(2'd2, 8'h01);
    core_read(2'd2, 8'h05, "status_cleared", 1);
    chk("irq_cleared", {7'd0, IRQ}, 8'h00);

    core_read(2'd0, 8'h00, "unf_before_rst", 1);
    ext_push(8'h41);
    ext_push(8'h42);
    ext_push(8'h43);
    core_write(2'd1, 8'h51);
    core_write(2'd1, 8'h52);
    core_read(2'd3, 8'h03, "cnt_mid", 1);
    core_read(2'd2, 8'h20, "status_mid", 1);
    SYS_RST = 1'b1;
    tick();
    SYS_RST = 1'b0;
    chk("post_rst_out_valid", {7'd0, OUT_VALID}, 8'h00);
    chk("post_rst_in_ready", {7'd0, IN_READY}, 8'h01);
    chk("post_rst_irq", {7'd0, IRQ}, 8'h00);
    core_read(2'd3, 8'h00, "post_rst_cnt", 1);
    core_read(2'd2, 8'h05, "post_rst_status", 1);
    ext_push(8'h5A);
    core_read(2'd0, 8'h5A, "post_rst_pop", 1);
    core_write(2'd1, 8'h6B);
    tx_q.push_back(8'h6B);
    drain_tx("post_rst_tx");

    repeat (2) tick();
    chk("rd_queue_empty", 8'(rd_q.size()), 8'h00);
    chk("tx_queue_empty", 8'(tx_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
